ram_bus_responder: RTL and testbench

RAM_BUS_RESPONDER -- requirements
Module: ram_bus_responder

---
 rtl/ram_bus_responder.sv | 157 +++++++++++++++
 tb/tb_ram_bus_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_responder.sv
// Byte-addressed RAM slave on a shared 64-bit tri-state data bus.
// Each access is captured in IDLE, waits WAIT_STATES cycles and completes in a
// single DONE cycle, where mem_ready (or fault for a misaligned access) pulses.
// Reads drive the bus only in DONE. Writes commit on the edge leaving DONE.
// Handshake: a request is accepted on a rising edge in IDLE when exactly one
// of mem_read/mem_write is high. Request inputs are ignored until the block
// is back in IDLE. Completion is the one-cycle mem_ready or fault pulse.
module ram_bus_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    inout  wire  [63:0] data,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    output logic        mem_ready,
    output logic        fault
);

    localparam int MEM_BYTES = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic                   is_write_q, is_write_d;
    logic [63:0]            wdata_q, wdata_d;
    logic                   conflict_q, conflict_d;

    logic [7:0]             mem_q [0:MEM_BYTES-1];

    logic [7:0]             byte_en;
    logic                   misaligned;
    logic                   commit;
    logic                   drive_en;
    logic [63:0]            rdata;

    // Upper address bits are deliberately ignored: storage wraps.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^address[31:ADDR_BITS];

    // Byte lanes covered by the captured size and the alignment test.
    always_comb begin
        byte_en    = 8'h01;
        misaligned = 1'b0;
        case (size_q)
            2'b00: begin byte_en = 8'h01; misaligned = 1'b0;            end
            2'b01: begin byte_en = 8'h03; misaligned = addr_q[0];       end
            2'b10: begin byte_en = 8'h0F; misaligned = |addr_q[1:0];    end
            default: begin byte_en = 8'hFF; misaligned = |addr_q[2:0];  end
        endcase
    end

    // Next-state logic: capture in IDLE, count down in WAIT, single DONE cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        conflict_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read ^ mem_write) begin
                    addr_d     = address[ADDR_BITS-1:0];
                    size_d     = size;
                    is_write_d = mem_write;
                    if (mem_write) begin
                        wdata_d = data;
                    end
                    if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end else if (mem_read && mem_write) begin
                    conflict_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and capture registers; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            is_write_q <= 1'b0;
            wdata_q    <= 64'd0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            conflict_q <= conflict_d;
        end
    end

    assign commit = !reset && (state_q == ST_DONE) && is_write_q && !misaligned;

    // Storage is not reset; a write lands only on a clean exit from DONE.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem_q[addr_q + ADDR_BITS'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Read data: selected bytes little-endian, zero-extended to 64 bits.
    always_comb begin
        rdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) begin
                rdata[8*i +: 8] = mem_q[addr_q + ADDR_BITS'(i)];
            end
        end
    end

    assign drive_en  = (state_q == ST_DONE) && !is_write_q && !misaligned;
    assign data      = drive_en ? rdata : 64'bz;
    assign mem_ready = (state_q == ST_DONE) && !misaligned;
    assign fault     = ((state_q == ST_DONE) && misaligned) || conflict_q;

endmodule

// File: tb/tb_ram_bus_responder.sv
// Bench for ram_bus_responder: two instances (WAIT_STATES=1 and 0) share the
// request wires, with strobes steered by sel. A byte-array model predicts
// read data, completion latency and fault for directed and random accesses.
module tb_ram_bus_responder;

  localparam int MEM_BYTES = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [1:0]  size;
  logic        mem_read;
  logic        mem_write;
  logic        sel;
  logic [63:0] tb_data;
  logic        tb_drive;

  tri0 [63:0]  data0;
  tri0 [63:0]  data1;
  wire         ready0, fault0, ready1, fault1;
  wire         rd0 = mem_read  & ~sel;
  wire         wr0 = mem_write & ~sel;
  wire         rd1 = mem_read  &  sel;
  wire         wr1 = mem_write &  sel;

  assign data0 = (tb_drive && !sel) ? tb_data : 64'bz;
  assign data1 = (tb_drive &&  sel) ? tb_data : 64'bz;

  wire         obs_ready = sel ? ready1 : ready0;
  wire         obs_fault = sel ? fault1 : fault0;
  wire [63:0]  obs_data  = sel ? data1  : data0;

  ram_bus_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) u_dut (
    .clock(clock), .reset(reset), .address(address), .data(data0),
    .mem_write(wr0), .mem_read(rd0), .size(size),
    .mem_ready(ready0), .fault(fault0)
  );

  ram_bus_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_dut_ws0 (
    .clock(clock), .reset(reset), .address(address), .data(data1),
    .mem_write(wr1), .mem_read(rd1), .size(size),
    .mem_ready(ready1), .fault(fault1)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] model [2][MEM_BYTES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: bytes at addr mod MEM_BYTES, little-endian, zero-extended.
  function automatic logic [63:0] model_read(input int s, input logic [31:0] addr, input logic [1:0] sz);
    logic [63:0] r;
    int base, n;
    r = 64'd0;
    n = 1 << sz;
    base = int'(addr % MEM_BYTES);
    for (int i = 0; i < n; i++) r[8*i +: 8] = model[s][(base + i) % MEM_BYTES];
    return r;
  endfunction

  task automatic model_write(input int s, input logic [31:0] addr, input logic [1:0] sz, input logic [63:0] wd);
    int base, n;
    n = 1 << sz;
    base = int'(addr % MEM_BYTES);
    for (int i = 0; i < n; i++) model[s][(base + i) % MEM_BYTES] = wd[8*i +: 8];
  endtask

  // driver: one full access, checked against the model
  task automatic run_op(input int s, input logic rd, input logic [31:0] addr, input logic [1:0] sz,
                        input logic [63:0] wd, input string tag, output logic [63:0] got_data);
    int n, ws, lat;
    logic aligned, got_ready, got_fault;
    logic [63:0] exp_rd;
    n = 1 << sz;
    ws = (s == 0) ? 1 : 0;
    aligned = ((addr % n) == 0);
    exp_rd = model_read(s, addr, sz);
    got_data = 64'd0;
    got_ready = 1'b0;
    got_fault = 1'b0;
    @(negedge clock);
    sel = s[0];
    mem_read = rd;
    mem_write = !rd;
    address = addr;
    size = sz;
    tb_data = wd;
    tb_drive = !rd;
    @(posedge clock);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    address = $urandom;
    size = 2'($urandom_range(0, 3));
    if (!rd) tb_data = {$urandom, $urandom};
    else tb_drive = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clock);
      if (obs_ready || obs_fault) begin
        lat = c;
        got_ready = obs_ready;
        got_fault = obs_fault;
        got_data = obs_data;
      end else if (rd) begin
        check({tag, "_bus_wait"}, obs_data, 64'd0);
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(ws + 1));
    check({tag, "_ready"}, 64'(got_ready), 64'(aligned));
    check({tag, "_fault"}, 64'(got_fault), 64'(!aligned));
    if (rd) check({tag, "_rdata"}, got_data, aligned ? exp_rd : 64'd0);
    if (!rd && aligned) model_write(s, addr, sz, wd);
    tb_drive = 1'b0;
    @(negedge clock);
    check({tag, "_ready_after"}, 64'(obs_ready), 64'd0);
    check({tag, "_fault_after"}, 64'(obs_fault), 64'd0);
    if (rd) check({tag, "_bus_after"}, obs_data, 64'd0);
  endtask

  task automatic conflict_op(input int s);
    @(negedge clock);
    sel = s[0];
    mem_read = 1'b1;
    mem_write = 1'b1;
    address = $urandom;
    size = 2'($urandom_range(0, 3));
    tb_drive = 1'b0;
    @(posedge clock);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clock);
    check("conflict_fault", 64'(obs_fault), 64'd1);
    check("conflict_ready", 64'(obs_ready), 64'd0);
    @(negedge clock);
    check("conflict_fault_clr", 64'(obs_fault), 64'd0);
    check("conflict_idle_ready", 64'(obs_ready), 64'd0);
  endtask

  // Accept a write at 0, then reset in WAIT (ws=1) or DONE (ws=0).
  task automatic reset_mid_write(input int s);
    logic [63:0] prior, got;
    prior = model_read(s, 32'd0, 2'b11);
    @(negedge clock);
    sel = s[0];
    mem_write = 1'b1;
    address = 32'd0;
    size = 2'b11;
    tb_data = 64'h1234;
    tb_drive = 1'b1;
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    tb_drive = 1'b0;
    @(negedge clock);
    check("rst_mid_ready_lat1", 64'(obs_ready), (s == 1) ? 64'd1 : 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("rst_mid_no_ready", 64'(obs_ready), 64'd0);
      check("rst_mid_no_fault", 64'(obs_fault), 64'd0);
    end
    run_op(s, 1'b1, 32'd0, 2'b11, 64'd0, "rst_mid_read", got);
    check("rst_mid_prior", got, prior);
  endtask

  initial begin
    logic [63:0] got;
    logic [31:0] a;
    logic [1:0]  sz;
    int s;
    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    address = 32'd0;
    size = 2'b00;
    sel = 1'b0;
    tb_data = 64'd0;
    tb_drive = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_ready0", 64'(ready0), 64'd0);
    check("rst_fault0", 64'(fault0), 64'd0);
    check("rst_bus0", data0, 64'd0);
    check("rst_ready1", 64'(ready1), 64'd0);
    check("rst_fault1", 64'(fault1), 64'd0);
    check("rst_bus1", data1, 64'd0);

    // Known contents everywhere before any read.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < MEM_BYTES; i += 8)
        run_op(k, 1'b0, 32'(i), 2'b11, {$urandom, $urandom}, "fill", got);

    // Double write/read
    run_op(0, 1'b0, 32'd24, 2'b11, 64'hFFFF_FFFF_FFFF_FFE8, "dbl_wr", got);
    run_op(0, 1'b1, 32'd24, 2'b11, 64'd0, "dbl_rd", got);
    check("dbl_value", got, 64'hFFFF_FFFF_FFFF_FFE8);

    // Sub-word
    run_op(0, 1'b0, 32'd25, 2'b00, 64'h0000_0000_0000_005A, "byte_wr", got);
    run_op(0, 1'b1, 32'd24, 2'b11, 64'd0, "sub_rd64", got);
    check("sub_value64", got, 64'hFFFF_FFFF_FFFF_5AE8);
    run_op(0, 1'b1, 32'd24, 2'b01, 64'd0, "sub_rd16", got);
    check("sub_value16", got, 64'h0000_0000_0000_5AE8);

    // Misaligned
    run_op(0, 1'b1, 32'd26, 2'b10, 64'd0, "mis_rd", got);
    run_op(0, 1'b0, 32'd28, 2'b11, 64'h0123_4567_89AB_CDEF, "mis_wr", got);
    run_op(0, 1'b1, 32'd24, 2'b11, 64'd0, "mis_after", got);
    check("mis_unchanged", got, 64'hFFFF_FFFF_FFFF_5AE8);

    // Conflict and wrap
    conflict_op(0);
    conflict_op(1);
    run_op(0, 1'b0, 32'd259, 2'b00, 64'h11, "wrap_wr", got);
    run_op(0, 1'b1, 32'd3, 2'b00, 64'd0, "wrap_rd", got);
    check("wrap_value", got, 64'h11);

    // Reset mid-access
    reset_mid_write(0);
    reset_mid_write(1);

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 9) == 0) conflict_op(s);
      else run_op(s, 1'($urandom_range(0, 1)), a, sz, {$urandom, $urandom}, "rand", got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
